// File: rtl/mem_copy_engine.sv
// Block copy / fill initiator for the single-port RAM.
// Copies words src->dst (overlap-safe direction) or fills dst with a constant.
module mem_copy_engine #(
    parameter int AW = 13,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_mode;
    logic          r_back;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_fill;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_off;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_load;
    logic          r_busy;
    logic          r_done;

    logic [AW:0]   w_len_c;
    logic [AW-1:0] w_diff;
    logic          w_back;
    logic [AW-1:0] w_off0;
    logic [AW-1:0] w_off_nx;
    logic          w_last;

    // Any request with bit AW set is at least 2^AW words, so clamp to exactly 2^AW.
    assign w_len_c  = len[AW] ? {1'b1, {AW{1'b0}}} : len;
    assign w_diff   = dst - src;
    assign w_back   = (dst != src) && ({1'b0, w_diff} < w_len_c);
    assign w_off0   = w_back ? (w_len_c[AW-1:0] - AW'(1)) : '0;
    assign w_off_nx = r_back ? (r_off - AW'(1)) : (r_off + AW'(1));
    assign w_last   = (r_count == (AW+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_back  <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_back  <= w_back;
                        r_src   <= src;
                        r_dst   <= dst;
                        r_fill  <= fill_val;
                        r_count <= w_len_c;
                        r_off   <= w_off0;
                        if (w_len_c == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else if (!mode) begin
                            r_state <= S_RD;
                            r_addr  <= src + w_off0;
                            r_load  <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                            r_addr  <= dst + w_off0;
                            r_data  <= fill_val;
                            r_load  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_WR;
                    r_data  <= mem_out;
                    r_addr  <= r_dst + r_off;
                    r_load  <= 1'b1;
                end
                S_WR, S_FILL: begin
                    r_count <= r_count - (AW+1)'(1);
                    r_off   <= w_off_nx;
                    if (w_last) begin
                        r_state <= S_FIN;
                        r_load  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == S_WR) begin
                        r_state <= S_RD;
                        r_addr  <= r_src + w_off_nx;
                        r_load  <= 1'b0;
                    end else begin
                        r_addr  <= r_dst + w_off_nx;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_in   = r_data;
    assign mem_load = r_load;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
